// File: rtl/usb2_ep_in_packer_if.sv
// Stream-side and endpoint-buffer-side signals of the IN packetizer.
// master: user logic + endpoint; slave: the packer itself.
interface usb2_ep_in_packer_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;
  logic       flush;

  logic [8:0] buf_in_addr;
  logic [7:0] buf_in_data;
  logic       buf_in_wren;
  logic       buf_in_ready;
  logic       buf_in_commit;
  logic [9:0] buf_in_commit_len;
  logic       buf_in_commit_ack;

  modport master (
    output s_data, s_valid, s_last, flush, buf_in_ready, buf_in_commit_ack,
    input  s_ready, buf_in_addr, buf_in_data, buf_in_wren, buf_in_commit,
           buf_in_commit_len
  );

  modport slave (
    input  s_data, s_valid, s_last, flush, buf_in_ready, buf_in_commit_ack,
    output s_ready, buf_in_addr, buf_in_data, buf_in_wren, buf_in_commit,
           buf_in_commit_len
  );
endinterface

// File: rtl/usb2_ep_in_packer.sv
// USB 2.0 IN endpoint packetizer: packs a byte stream into the endpoint
// buffer and runs the commit/ack/drain handshake with the phy_clk endpoint.
module usb2_ep_in_packer #(
  parameter int unsigned MAX_PKT     = 512,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     wr_clk,
  input  logic                     reset,
  usb2_ep_in_packer_if.slave       bus,
  output logic                     busy,
  output logic [15:0]              pkt_count
);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    WRITE_FLUSH,
    COMMIT,
    ACK_LOW,
    DRAIN
  } state_e;

  localparam logic [9:0] MAX_LEN = 10'(MAX_PKT);

  state_e state_q, state_d;

  logic [9:0]             count_q, count_d;
  logic [8:0]             addr_q, addr_d;
  logic [7:0]             data_q, data_d;
  logic                   wren_q, wren_d;
  logic                   commit_q, commit_d;
  logic [9:0]             commit_len_q, commit_len_d;
  logic [15:0]            pkt_count_q, pkt_count_d;
  logic [SYNC_STAGES-1:0] rdy_sync_q;
  logic [SYNC_STAGES-1:0] ack_sync_q;

  logic rdy_s;
  logic ack_s;
  logic accept;

  assign rdy_s = rdy_sync_q[SYNC_STAGES-1];
  assign ack_s = ack_sync_q[SYNC_STAGES-1];

  always_ff @(posedge wr_clk) begin
    if (reset) begin
      rdy_sync_q <= '0;
      ack_sync_q <= '0;
    end else begin
      rdy_sync_q[0] <= bus.buf_in_ready;
      ack_sync_q[0] <= bus.buf_in_commit_ack;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        rdy_sync_q[i] <= rdy_sync_q[i-1];
        ack_sync_q[i] <= ack_sync_q[i-1];
      end
    end
  end

  always_ff @(posedge wr_clk) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      wren_q       <= 1'b0;
      commit_q     <= 1'b0;
      commit_len_q <= '0;
      pkt_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      wren_q       <= wren_d;
      commit_q     <= commit_d;
      commit_len_q <= commit_len_d;
      pkt_count_q  <= pkt_count_d;
    end
  end

  assign accept = bus.s_valid && (state_q == FILL);

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    addr_d       = addr_q;
    data_d       = data_q;
    wren_d       = 1'b0;
    commit_len_d = commit_len_q;
    pkt_count_d  = pkt_count_q;

    unique case (state_q)
      IDLE: begin
        if (rdy_s) begin
          state_d = FILL;
          count_d = '0;
        end
      end
      FILL: begin
        if (accept) begin
          wren_d  = 1'b1;
          addr_d  = count_q[8:0];
          data_d  = bus.s_data;
          count_d = count_q + 10'd1;
          // A flush arriving with a byte still takes the byte before closing.
          if (bus.s_last || bus.flush || (count_q + 10'd1 == MAX_LEN)) begin
            state_d = WRITE_FLUSH;
          end
        end else if (bus.flush) begin
          state_d = WRITE_FLUSH;
        end
      end
      WRITE_FLUSH: begin
        commit_len_d = count_q;
        state_d      = COMMIT;
      end
      COMMIT: begin
        if (ack_s) begin
          pkt_count_d = pkt_count_q + 16'd1;
          state_d     = ACK_LOW;
        end
      end
      ACK_LOW: begin
        if (!ack_s) state_d = DRAIN;
      end
      DRAIN: begin
        // Stale ready from the just-committed buffer must clear before refill.
        if (!rdy_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    commit_d = (state_d == COMMIT);
  end

  assign bus.s_ready           = (state_q == FILL);
  assign bus.buf_in_addr       = addr_q;
  assign bus.buf_in_data       = data_q;
  assign bus.buf_in_wren       = wren_q;
  assign bus.buf_in_commit     = commit_q;
  assign bus.buf_in_commit_len = commit_len_q;
  assign busy                  = (state_q != IDLE);
  assign pkt_count             = pkt_count_q;

endmodule

// File: tb/tb_usb2_ep_in_packer.sv
// Randomized bench for usb2_ep_in_packer; expectations come from a packet-level
// model (byte index within packet, close rules, commit count).
module tb_usb2_ep_in_packer;
  localparam int unsigned MAX_PKT = 512;
  localparam int unsigned SYNC    = 2;

  logic        wr_clk = 1'b0;
  logic        reset  = 1'b1;
  logic        busy;
  logic [15:0] pkt_count;

  usb2_ep_in_packer_if bus();

  usb2_ep_in_packer #(.MAX_PKT(MAX_PKT), .SYNC_STAGES(SYNC)) dut (
    .wr_clk    (wr_clk),
    .reset     (reset),
    .bus       (bus),
    .busy      (busy),
    .pkt_count (pkt_count)
  );

  always #5 wr_clk = ~wr_clk;

  int          total = 0;
  int          bad   = 0;
  int unsigned m_len  = 0;
  int unsigned m_pkts = 0;
  bit          skip_hs = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input bit chk_rdy);
    @(posedge wr_clk);
    #1;
    chk("idle_wren", 32'(bus.buf_in_wren), 32'd0);
    if (chk_rdy) chk("backpressure", 32'(bus.s_ready), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_last = 1'b0;
    bus.flush = 1'b0;
    bus.buf_in_commit_ack = 1'b0;
    bus.buf_in_ready = 1'b0;
    @(posedge wr_clk);
    #1;
    chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
    chk("rst_addr", 32'(bus.buf_in_addr), 32'd0);
    chk("rst_data", 32'(bus.buf_in_data), 32'd0);
    chk("rst_wren", 32'(bus.buf_in_wren), 32'd0);
    chk("rst_commit", 32'(bus.buf_in_commit), 32'd0);
    chk("rst_len", 32'(bus.buf_in_commit_len), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pkt_count", 32'(pkt_count), 32'd0);
    @(posedge wr_clk);
    #1;
    reset = 1'b0;
    m_len = 0;
    m_pkts = 0;
  endtask

  task automatic wait_fill();
    int unsigned n;
    bus.s_valid = 1'b0;
    bus.flush = 1'b0;
    bus.buf_in_ready = 1'b1;
    n = 0;
    while (bus.s_ready !== 1'b1 && n < SYNC + 1) begin
      tick(1'b0);
      n++;
    end
    chk("fill_entry", 32'(bus.s_ready), 32'd1);
  endtask

  task automatic handshake();
    int unsigned n;
    bus.s_valid = 1'b1;
    bus.s_data = 8'($urandom);
    n = 0;
    while (bus.buf_in_commit !== 1'b1 && n < 4) begin
      tick(1'b1);
      n++;
    end
    chk("commit_rise", 32'(bus.buf_in_commit), 32'd1);
    chk("commit_len", 32'(bus.buf_in_commit_len), m_len);
    // flush pulses here fall outside FILL and must not start another packet
    bus.flush = 1'b1;
    repeat ($urandom_range(1, 3)) begin
      tick(1'b1);
      bus.flush = 1'($urandom_range(0, 1));
    end
    bus.flush = 1'b0;
    chk("commit_hold", 32'(bus.buf_in_commit), 32'd1);
    bus.buf_in_commit_ack = 1'b1;
    n = 0;
    while (bus.buf_in_commit !== 1'b0 && n < SYNC + 2) begin
      tick(1'b1);
      n++;
    end
    chk("commit_fall", 32'(bus.buf_in_commit), 32'd0);
    m_pkts = (m_pkts + 1) % 65536;
    chk("pkt_count", 32'(pkt_count), m_pkts);
    repeat ($urandom_range(1, 4)) tick(1'b1);
    bus.buf_in_commit_ack = 1'b0;
    bus.buf_in_ready = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 3 * SYNC + 4) begin
      tick(1'b1);
      n++;
    end
    chk("drain_idle", 32'(busy), 32'd0);
    chk("commit_after", 32'(bus.buf_in_commit), 32'd0);
    repeat ($urandom_range(0, 5)) tick(1'b1);
    m_len = 0;
    wait_fill();
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit l, input bit f);
    bit close;
    bus.s_valid = v;
    bus.s_data = d;
    bus.s_last = l;
    bus.flush = f;
    chk("s_ready", 32'(bus.s_ready), 32'd1);
    chk("commit_idle", 32'(bus.buf_in_commit), 32'd0);
    @(posedge wr_clk);
    #1;
    close = f;
    if (v) begin
      chk("wr_en", 32'(bus.buf_in_wren), 32'd1);
      chk("wr_addr", 32'(bus.buf_in_addr), m_len % 512);
      chk("wr_data", 32'(bus.buf_in_data), 32'(d));
      m_len++;
      if (l || m_len == MAX_PKT) close = 1'b1;
    end else begin
      chk("no_wr", 32'(bus.buf_in_wren), 32'd0);
    end
    bus.s_valid = 1'b0;
    bus.s_last = 1'b0;
    bus.flush = 1'b0;
    if (close && !skip_hs) handshake();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned n;
    bus.s_data = '0;
    do_reset();

    // ready held low: no fill, no writes
    repeat (8) tick(1'b1);
    wait_fill();

    for (int i = 0; i < 5; i++) step(1'b1, 8'(16 + i), i == 4, 1'b0);

    // 600 bytes: forced close at MAX_PKT, remainder closed by last
    for (int i = 0; i < 600; i++) step(1'b1, 8'(i * 7), i == 599, 1'b0);

    // zero-length packet
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // flush with the last byte at count 2
    step(1'b1, 8'hA1, 1'b0, 1'b0);
    step(1'b1, 8'hA2, 1'b0, 1'b0);
    step(1'b1, 8'hA3, 1'b1, 1'b1);
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);

    // reset while committing a 3-byte packet
    skip_hs = 1'b1;
    step(1'b1, 8'h31, 1'b0, 1'b0);
    step(1'b1, 8'h32, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b1, 1'b0);
    skip_hs = 1'b0;
    n = 0;
    while (bus.buf_in_commit !== 1'b1 && n < 4) begin
      tick(1'b1);
      n++;
    end
    chk("mid_commit", 32'(bus.buf_in_commit), 32'd1);
    do_reset();
    wait_fill();

    for (int i = 0; i < 300; i++) begin
      bit v;
      v = ($urandom_range(0, 9) < 7);
      step(v, 8'($urandom), v && ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 29) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
